fft_ctrl: RTL and testbench
===========================

FFT_CTRL -- requirements
Module: fft_ctrl

Interface
REQ-001 SHALL have parameter LOG2N, default 4, meaning log2 of FFT size N (N = 2^LOG2N, N/2 butterflies per stage).
REQ-002 SHALL have parameter PIPE, default 2, meaning cycles from rd_en to matching wr_en (memory read plus butterfly register).
REQ-003 SHALL have port clk  in  1  rising-edge clock; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port rst_n  in  1  synchronous active-low reset.
REQ-005 SHALL have port start  in  1  request to run one in-place radix-2 DIF FFT.
REQ-006 SHALL have port busy  out  1  high while stages are running or draining.
REQ-007 SHALL have port done  out  1  one-cycle pulse when the transform is complete.
REQ-008 SHALL have port stage  out  4  current stage index, 0..LOG2N-1.
REQ-009 SHALL have port rd_en  out  1  read strobe for operand pair p/q.
REQ-010 SHALL have port rd_addr_p, rd_addr_q  out  LOG2N each  butterfly operand addresses p and q.
REQ-011 SHALL have port tw_addr  out  LOG2N-1  twiddle ROM index for W_N^tw_addr, valid with rd_en.
REQ-012 SHALL have port wr_en  out  1  write-back strobe for butterfly results yp/yq.
REQ-013 SHALL have port wr_addr_p, wr_addr_q  out  LOG2N each  write-back addresses.

Function
REQ-014 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE: on an edge with start=1, SHALL load stage=0 and k=0 (butterfly counter, LOG2N-1 bits) and go to RUN; start=0 stays in IDLE.
REQ-016 RUN: every cycle SHALL assert rd_en with span=N>>(stage+1), j=k mod span, g=k/span, p=2*g*span+j, q=p+span, tw_addr=j<<stage.
REQ-017 RUN: k SHALL increment each cycle; in the cycle with k=N/2-1, SHALL go to DRAIN with a drain counter loaded to PIPE.
REQ-018 DRAIN: rd_en SHALL be 0 for exactly PIPE cycles; afterwards go to DONE if stage=LOG2N-1, else stage+1, k=0, RUN.
REQ-019 DONE: SHALL assert done for exactly one cycle, then go to IDLE.
REQ-020 busy SHALL be 1 in RUN and DRAIN and 0 in IDLE and DONE.
REQ-021 wr_en, wr_addr_p and wr_addr_q SHALL equal rd_en, rd_addr_p and rd_addr_q delayed exactly PIPE cycles through a shift pipeline.
REQ-022 The last write of a stage SHALL occur in the final DRAIN cycle; the first read of the next stage SHALL occur the following cycle (no read-after-write hazard).
REQ-023 start SHALL be ignored while busy=1 or in DONE; no queuing.
REQ-024 The busy window SHALL be exactly LOG2N*(N/2+PIPE) cycles, followed by the done cycle.
REQ-025 When rd_en=0, rd/tw addresses SHALL be held at 0; when wr_en=0, wr addresses SHALL be held at 0.
REQ-026 All counters SHALL wrap-free by construction; k never exceeds N/2-1 and stage never exceeds LOG2N-1.

Reset
REQ-027 While rst_n=0 at a clock edge: state=IDLE, busy=0, done=0, stage=0, rd_en=0, wr_en=0, all addresses 0, and every PIPE stage cleared.
REQ-028 Reset asserted mid-transform SHALL abort with no further wr_en pulses, including any writes still in the pipeline.
REQ-029 start sampled in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-030 LOG2N=4, PIPE=2, start pulse -> busy high for 40 cycles, done pulses on cycle 41, 32 rd_en and 32 wr_en pulses total.
REQ-031 Stage 0 -> k=0: p=0, q=8, tw=0; k=3: p=3, q=11, tw=3; Stage 1, k=5 -> p=9, q=13, tw=2; Stage 3, k=7 -> p=14, q=15, tw=0.
REQ-032 Pipeline check -> each wr_en occurs PIPE cycles after its rd_en with identical p/q; the first stage-1 read occurs the cycle after the last stage-0 write.
REQ-033 start held high for the whole run -> exactly one transform is run, and a second starts only from IDLE after done.
REQ-034 rst_n low at busy cycle 13 -> the next edge shows all outputs 0, no wr_en afterwards; a new start runs a full 40-cycle transform.
REQ-035 Scoreboard with the butterfly datapath, memory model and twiddle ROM, impulse input x[0]=1 -> every output bin equals 1 (bit-reversed order).

Source files
------------

// File: rtl/fft_ctrl.sv
// Address/sequence controller for an in-place radix-2 DIF FFT.
// Issues N/2 butterfly reads per stage and mirrors them PIPE cycles later as write-backs.
module fft_ctrl #(
    parameter int LOG2N = 4,
    parameter int PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       stage,
    output logic             rd_en,
    output logic [LOG2N-1:0] rd_addr_p,
    output logic [LOG2N-1:0] rd_addr_q,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_en,
    output logic [LOG2N-1:0] wr_addr_p,
    output logic [LOG2N-1:0] wr_addr_q
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int KW = LOG2N - 1;
    localparam int DW = $clog2(PIPE + 1);

    localparam logic [KW-1:0]    K_LAST     = {KW{1'b1}};
    localparam logic [DW-1:0]    DRAIN_LOAD = DW'(PIPE);
    localparam logic [DW-1:0]    DRAIN_ONE  = DW'(1);
    localparam logic [3:0]       STAGE_LAST = 4'(LOG2N - 1);
    localparam logic [LOG2N-1:0] ADDR_ONE   = LOG2N'(1);

    logic [1:0]    state_reg, state_next;
    logic [3:0]    stage_reg, stage_next;
    logic [KW-1:0] k_reg, k_next;
    logic [DW-1:0] drain_reg, drain_next;

    // Next-state logic: counters are reloaded on every exit so nothing ever wraps.
    always_comb begin
        state_next = state_reg;
        stage_next = stage_reg;
        k_next     = k_reg;
        drain_next = drain_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                    stage_next = 4'd0;
                    k_next     = '0;
                end
            end
            S_RUN: begin
                if (k_reg == K_LAST) begin
                    state_next = S_DRAIN;
                    drain_next = DRAIN_LOAD;
                    k_next     = '0;
                end else begin
                    k_next = k_reg + KW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_reg == DRAIN_ONE) begin
                    drain_next = '0;
                    if (stage_reg == STAGE_LAST) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_RUN;
                        stage_next = stage_reg + 4'd1;
                        k_next     = '0;
                    end
                end else begin
                    drain_next = drain_reg - DRAIN_ONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            stage_reg <= 4'd0;
            k_reg     <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            stage_reg <= stage_next;
            k_reg     <= k_next;
            drain_reg <= drain_next;
        end
    end

    // span is a power of two, so k mod span / k div span reduce to masking.
    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] span;
    logic [LOG2N-1:0] mask;
    logic [LOG2N-1:0] j_val;
    logic [LOG2N-1:0] p_val;
    logic [LOG2N-1:0] tw_full;

    always_comb begin
        k_ext   = {1'b0, k_reg};
        span    = ADDR_ONE << (STAGE_LAST - stage_reg);
        mask    = span - ADDR_ONE;
        j_val   = k_ext & mask;
        p_val   = ((k_ext & ~mask) << 1) | j_val;
        tw_full = j_val << stage_reg;
    end

    assign busy      = (state_reg == S_RUN) || (state_reg == S_DRAIN);
    assign done      = (state_reg == S_DONE);
    assign stage     = stage_reg;
    assign rd_en     = (state_reg == S_RUN);
    assign rd_addr_p = rd_en ? p_val : '0;
    assign rd_addr_q = rd_en ? (p_val | span) : '0;
    assign tw_addr   = rd_en ? tw_full[LOG2N-2:0] : '0;

    // Write-back delay line; addresses enter already zeroed when idle.
    logic             pipe_en_reg [PIPE];
    logic [LOG2N-1:0] pipe_p_reg  [PIPE];
    logic [LOG2N-1:0] pipe_q_reg  [PIPE];

    genvar gi;
    generate
        for (gi = 0; gi < PIPE; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        pipe_en_reg[gi] <= 1'b0;
                        pipe_p_reg[gi]  <= '0;
                        pipe_q_reg[gi]  <= '0;
                    end else begin
                        pipe_en_reg[gi] <= rd_en;
                        pipe_p_reg[gi]  <= rd_addr_p;
                        pipe_q_reg[gi]  <= rd_addr_q;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        pipe_en_reg[gi] <= 1'b0;
                        pipe_p_reg[gi]  <= '0;
                        pipe_q_reg[gi]  <= '0;
                    end else begin
                        pipe_en_reg[gi] <= pipe_en_reg[gi-1];
                        pipe_p_reg[gi]  <= pipe_p_reg[gi-1];
                        pipe_q_reg[gi]  <= pipe_q_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign wr_en     = pipe_en_reg[PIPE-1];
    assign wr_addr_p = pipe_p_reg[PIPE-1];
    assign wr_addr_q = pipe_q_reg[PIPE-1];

endmodule

// File: tb/tb_fft_ctrl.sv
// Bench for fft_ctrl: per-cycle schedule model plus a complex-valued memory/butterfly
// scoreboard whose final contents are compared with a direct DFT in bit-reversed order.
module tb_fft_ctrl;
    localparam int LOG2N    = 4;
    localparam int PIPE     = 2;
    localparam int N        = 1 << LOG2N;
    localparam int HALF     = N / 2;
    localparam int SEG      = HALF + PIPE;
    localparam int BUSY_CYC = LOG2N * SEG;
    localparam real PI      = 3.141592653589793;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             busy, done, rd_en, wr_en;
    logic [3:0]       stage;
    logic [LOG2N-1:0] rd_addr_p, rd_addr_q, wr_addr_p, wr_addr_q;
    logic [LOG2N-2:0] tw_addr;

    fft_ctrl #(.LOG2N(LOG2N), .PIPE(PIPE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .stage(stage), .rd_en(rd_en), .rd_addr_p(rd_addr_p), .rd_addr_q(rd_addr_q),
        .tw_addr(tw_addr), .wr_en(wr_en), .wr_addr_p(wr_addr_p), .wr_addr_q(wr_addr_q)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    real x_re [N];
    real x_im [N];
    real mem_re [N];
    real mem_im [N];

    typedef struct {
        int  p;
        int  q;
        int  tw;
        real ar;
        real ai;
        real br;
        real bi;
    } op_t;
    op_t opq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_real(input string tag, input real obs, input real exp_v);
        real d;
        d = obs - exp_v;
        if (d < 0.0) d = -d;
        checks++;
        assert (d < 1.0e-6) else begin
            failures++;
            $error("FAIL %s observed=%f expected=%f", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bitrev(input int v);
        int r = 0;
        for (int b = 0; b < LOG2N; b++) r = (r << 1) | ((v >> b) & 1);
        return r;
    endfunction

    task automatic load_data(input int impulse);
        for (int n = 0; n < N; n++) begin
            if (impulse != 0) begin
                x_re[n] = (n == 0) ? 1.0 : 0.0;
                x_im[n] = 0.0;
            end else begin
                x_re[n] = real'(int'($urandom_range(0, 2000)) - 1000) / 100.0;
                x_im[n] = real'(int'($urandom_range(0, 2000)) - 1000) / 100.0;
            end
            mem_re[n] = x_re[n];
            mem_im[n] = x_im[n];
        end
        opq.delete();
    endtask

    // Memory model driven by the DUT's own strobes and addresses.
    task automatic dp_step();
        op_t o;
        real c, s, dr, di;
        if (wr_en === 1'b1) begin
            chk("wr_has_pending_rd", opq.size() > 0, 1);
            if (opq.size() > 0) begin
                o = opq.pop_front();
                chk("wr_p_matches_rd", wr_addr_p, o.p);
                chk("wr_q_matches_rd", wr_addr_q, o.q);
                c = $cos(2.0 * PI * real'(o.tw) / real'(N));
                s = $sin(2.0 * PI * real'(o.tw) / real'(N));
                dr = o.ar - o.br;
                di = o.ai - o.bi;
                mem_re[int'(wr_addr_p)] = o.ar + o.br;
                mem_im[int'(wr_addr_p)] = o.ai + o.bi;
                mem_re[int'(wr_addr_q)] = dr * c + di * s;
                mem_im[int'(wr_addr_q)] = di * c - dr * s;
            end
        end
        if (rd_en === 1'b1) begin
            o.p  = int'(rd_addr_p);
            o.q  = int'(rd_addr_q);
            o.tw = int'(tw_addr);
            o.ar = mem_re[o.p];
            o.ai = mem_im[o.p];
            o.br = mem_re[o.q];
            o.bi = mem_im[o.q];
            opq.push_back(o);
        end
    endtask

    task automatic check_result(input string name);
        real xr, xi, ang;
        for (int k = 0; k < N; k++) begin
            xr = 0.0;
            xi = 0.0;
            for (int n = 0; n < N; n++) begin
                ang = 2.0 * PI * real'(n * k) / real'(N);
                xr += x_re[n] * $cos(ang) + x_im[n] * $sin(ang);
                xi += x_im[n] * $cos(ang) - x_re[n] * $sin(ang);
            end
            chk_real($sformatf("%s_bin%0d_re", name, k), mem_re[bitrev(k)], xr);
            chk_real($sformatf("%s_bin%0d_im", name, k), mem_im[bitrev(k)], xi);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_done"}, done, 0);
        chk({name, "_stage"}, stage, 0);
        chk({name, "_rd_en"}, rd_en, 0);
        chk({name, "_rd_p"}, rd_addr_p, 0);
        chk({name, "_rd_q"}, rd_addr_q, 0);
        chk({name, "_tw"}, tw_addr, 0);
        chk({name, "_wr_en"}, wr_en, 0);
        chk({name, "_wr_p"}, wr_addr_p, 0);
        chk({name, "_wr_q"}, wr_addr_q, 0);
    endtask

    // Called at the sample point of busy cycle 0; mode 0 = start low, 1 = held, 2 = random.
    task automatic check_window(input string name, input int mode);
        int s, r, k, span, e_rd, e_p, e_q, e_tw, e_wr, e_wp, e_wq;
        int rd_cnt = 0;
        int wr_cnt = 0;
        for (int t = 0; t < BUSY_CYC; t++) begin
            s = t / SEG;
            r = t % SEG;
            span = N >> (s + 1);
            e_rd = (r < HALF) ? 1 : 0;
            k = r;
            e_p  = e_rd ? 2 * (k / span) * span + (k % span) : 0;
            e_q  = e_rd ? e_p + span : 0;
            e_tw = e_rd ? (k % span) << s : 0;
            e_wr = (r >= PIPE) ? 1 : 0;
            k = r - PIPE;
            e_wp = e_wr ? 2 * (k / span) * span + (k % span) : 0;
            e_wq = e_wr ? e_wp + span : 0;
            chk($sformatf("%s_t%0d_busy", name, t), busy, 1);
            chk($sformatf("%s_t%0d_done", name, t), done, 0);
            chk($sformatf("%s_t%0d_stage", name, t), stage, s);
            chk($sformatf("%s_t%0d_rd_en", name, t), rd_en, e_rd);
            chk($sformatf("%s_t%0d_rd_p", name, t), rd_addr_p, e_p);
            chk($sformatf("%s_t%0d_rd_q", name, t), rd_addr_q, e_q);
            chk($sformatf("%s_t%0d_tw", name, t), tw_addr, e_tw);
            chk($sformatf("%s_t%0d_wr_en", name, t), wr_en, e_wr);
            chk($sformatf("%s_t%0d_wr_p", name, t), wr_addr_p, e_wp);
            chk($sformatf("%s_t%0d_wr_q", name, t), wr_addr_q, e_wq);
            if (rd_en === 1'b1) rd_cnt++;
            if (wr_en === 1'b1) wr_cnt++;
            dp_step();
            if (mode == 2) start = 1'($urandom_range(0, 1));
            tick();
        end
        chk({name, "_done_pulse"}, done, 1);
        chk({name, "_done_busy"}, busy, 0);
        chk({name, "_done_rd_en"}, rd_en, 0);
        chk({name, "_done_wr_en"}, wr_en, 0);
        chk({name, "_rd_count"}, rd_cnt, LOG2N * HALF);
        chk({name, "_wr_count"}, wr_cnt, LOG2N * HALF);
        chk({name, "_queue_empty"}, opq.size(), 0);
        start = (mode == 1);
        tick();
        chk({name, "_after_done"}, done, 0);
        chk({name, "_after_busy"}, busy, 0);
        $display("transaction %s: %0d reads, %0d writes, done after %0d busy cycles",
                 name, rd_cnt, wr_cnt, BUSY_CYC);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with start high: start must not be taken.
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        chk("post_reset_idle", busy, 0);

        // Impulse: every bin must be 1.
        load_data(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_window("impulse", 0);
        for (int k = 0; k < N; k++) chk_real($sformatf("impulse_bin%0d_one", k), mem_re[k], 1.0);
        check_result("impulse");

        // start held through a run and into the IDLE cycle.
        load_data(0);
        start = 1'b1;
        tick();
        check_window("held_first", 1);
        load_data(0);
        tick();
        start = 1'b0;
        check_window("held_second", 0);
        check_result("held_second");

        // Random gaps, random data, start toggling while busy.
        for (int i = 0; i < 3; i++) begin
            int gap;
            gap = int'($urandom_range(0, 4));
            for (int g = 0; g < gap; g++) begin
                chk($sformatf("gap%0d_%0d_busy", i, g), busy, 0);
                tick();
            end
            load_data(0);
            start = 1'b1;
            tick();
            start = 1'b0;
            check_window($sformatf("rand%0d", i), 2);
            check_result($sformatf("rand%0d", i));
        end

        // Abort at busy cycle 13 with writes still in flight.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 13; t++) tick();
        chk("abort_pre_busy", busy, 1);
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        check_idle_outputs("abort");
        rst_n = 1'b1;
        start = 1'b0;
        for (int t = 0; t < 12; t++) begin
            chk($sformatf("abort_quiet%0d_wr_en", t), wr_en, 0);
            chk($sformatf("abort_quiet%0d_busy", t), busy, 0);
            tick();
        end
        $display("transaction abort: reset at busy cycle 13, outputs cleared");

        load_data(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_window("after_abort", 0);
        check_result("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
